// File: rtl/shot_sequencer.sv
// shot_sequencer: fast-gate armed, delayed single-pulse trigger with detector handshake.
// Optional READY_TIMEOUT_EN adds a detector_ready wait timeout leading to FAULT.
module shot_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int DELAY_W         = 24,
  parameter int PULSE_CYCLES    = 20,
  parameter int MAX_SHOTS       = 4,
  parameter int SHOT_W          = 8,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start_signal,
  input  logic               fg_signal,
  input  logic               detector_ready,
  input  logic [DELAY_W-1:0] trig_delay,
  output logic               output_trigger,
  output logic               armed,
  output logic               busy,
  output logic [SHOT_W-1:0]  shot_count,
  output logic               done,
  output logic               fault
);
  localparam int TW  = TIMEOUT_CYCLES > PULSE_CYCLES ? $clog2(TIMEOUT_CYCLES + 1) : $clog2(PULSE_CYCLES + 1);
  localparam int CW  = DELAY_W > TW ? DELAY_W : TW;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, FIRE, WAIT_ACK, WAIT_RDY, DONE, FAULT} state_t;

  state_t state, state_n;
  logic [SYNC_STAGES-1:0] start_sync, fg_sync, rdy_sync;
  logic start_s, fg_s, rdy_s, fg_prev, fg_edge, start_deb;
  logic [DBW-1:0] dbc;
  logic [CW-1:0] cnt, cnt_n;
  logic [SHOT_W-1:0] shot_n;

  assign start_s = start_sync[SYNC_STAGES-1];
  assign fg_s    = fg_sync[SYNC_STAGES-1];
  assign rdy_s   = rdy_sync[SYNC_STAGES-1];

  // fg_edge is registered so the trigger lands SYNC_STAGES+2+D clocks after the first fg sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_sync <= '0;
      fg_sync    <= '0;
      rdy_sync   <= '1;
      fg_prev    <= 1'b0;
      fg_edge    <= 1'b0;
      start_deb  <= 1'b0;
      dbc        <= '0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start_signal};
      fg_sync    <= {fg_sync[SYNC_STAGES-2:0], fg_signal};
      rdy_sync   <= {rdy_sync[SYNC_STAGES-2:0], detector_ready};
      fg_prev    <= fg_s;
      fg_edge    <= fg_s & ~fg_prev;
      dbc        <= (start_s == start_deb || dbc == DBW'(DEBOUNCE_CYCLES - 1)) ? '0 : dbc + 1'b1;
      if (start_s != start_deb && dbc == DBW'(DEBOUNCE_CYCLES - 1))
        start_deb <= start_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shot_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shot_count <= shot_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shot_n  = shot_count;
    case (state)
      IDLE: if (enable && start_deb) begin
        state_n = ARMED;
        shot_n  = '0;
      end
      ARMED: if (!start_deb || !enable) state_n = IDLE;
        else if (fg_edge) begin
          state_n = DELAY;
          cnt_n   = CW'(trig_delay);
        end
      DELAY: if (!start_deb || !enable) state_n = IDLE;
        else if (cnt == '0) begin
          state_n = FIRE;
          shot_n  = &shot_count ? shot_count : shot_count + 1'b1;
        end else cnt_n = cnt - 1'b1;
      FIRE: if (cnt == CW'(PULSE_CYCLES - 1)) begin
          state_n = WAIT_ACK;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      WAIT_ACK: state_n = !enable ? IDLE : !rdy_s ? WAIT_RDY : WAIT_ACK;
      WAIT_RDY: if (rdy_s) state_n = (MAX_SHOTS != 0 && shot_count == SHOT_W'(MAX_SHOTS)) ? DONE :
                                     (start_deb && enable) ? ARMED : IDLE;
        else if (!enable) state_n = IDLE;
      DONE:  if (!start_deb || !enable) state_n = IDLE;
      FAULT: if (!start_deb) state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef READY_TIMEOUT_EN
    if (state == WAIT_ACK || state == WAIT_RDY) begin
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(TIMEOUT_CYCLES - 1)) state_n = FAULT;
    end
`endif
  end

  assign output_trigger = state == FIRE;
  assign armed          = state == ARMED;
  assign busy           = state == DELAY || state == FIRE || state == WAIT_ACK || state == WAIT_RDY;
  assign done           = state == DONE;
`ifdef READY_TIMEOUT_EN
  assign fault          = state == FAULT;
`else
  assign fault          = 1'b0;
`endif
endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
Controls the synchronization block's trigger path. Once a debounced start condition is present, it arms on each fast-gate rising edge, waits a programmable delay, and emits one output_trigger pulse. It then holds until the detector has dropped and restored detector_ready. This repeats up to MAX_SHOTS per start window, and the block sits between the external gate and detector lines and the trigger output driver.

Parameters:
SYNC_STAGES, 2, flop stages on each asynchronous input (start_signal, fg_signal, detector_ready); minimum 2.
DEBOUNCE_CYCLES, 10, consecutive equal synced samples needed to change debounced start level.
DELAY_W, 24, width of trig_delay.
PULSE_CYCLES, 20, output_trigger high time in clocks; minimum 1.
MAX_SHOTS, 4, shots per start window; 0 = unlimited.
SHOT_W, 8, width of shot_count; saturates at all-ones.
TIMEOUT_CYCLES, 2000000, detector_ready wait limit (10 ms at 200 MHz); used only with READY_TIMEOUT_EN.

Ports:
clock  in  1  system clock, 200 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  synchronous; 0 forces IDLE after any in-progress pulse completes
start_signal  in  1  async start condition (run window)
fg_signal  in  1  async fast-gate signal
detector_ready  in  1  async, detector idle when 1
trig_delay  in  DELAY_W  clocks from fg edge detect to pulse; sampled on the fg edge
output_trigger  out  1  trigger pulse
armed  out  1  high in ARMED
busy  out  1  high in DELAY, FIRE, WAIT_ACK, WAIT_RDY
shot_count  out  SHOT_W  shots fired in current window
done  out  1  high in DONE
fault  out  1  high in FAULT; constant 0 without READY_TIMEOUT_EN

Behaviour:
- Reset values: all outputs 0, shot_count 0, state IDLE. Synchronizers for start/fg reset to 0; detector_ready synchronizer resets to 1. Debounced start resets to 0.
- Reset is honoured asynchronously in every state, including mid-pulse. output_trigger drops immediately.
- fg_edge: one-cycle strobe when the synced fg is 1 and its previous value was 0.
- start_deb: changes level only after DEBOUNCE_CYCLES consecutive synced samples at the new level.
- IDLE: if enable & start_deb, go to ARMED and clear shot_count.
- ARMED:
  - If !start_deb or !enable, go to IDLE.
  - Else on fg_edge, latch trig_delay into the counter and go to DELAY.
- DELAY: count down each clock. When the counter reaches 0, go to FIRE, so trig_delay=0 means FIRE on the next cycle. If start_deb falls, go to IDLE with no pulse (abort). fg_edge is ignored.
- FIRE: output_trigger=1 for exactly PULSE_CYCLES clocks, then go to WAIT_ACK. shot_count increments once, on FIRE entry. FIRE always completes regardless of start, enable, or fg.
- Latency: output_trigger rises exactly SYNC_STAGES+2+D clocks after the first clock edge sampling fg_signal=1, where D is the trig_delay value.
- WAIT_ACK: wait for synced detector_ready=0, then go to WAIT_RDY.
- WAIT_RDY: wait for synced detector_ready=1, then:
  - If MAX_SHOTS!=0 and shot_count==MAX_SHOTS, go to DONE.
  - Else if start_deb & enable, go to ARMED.
  - Else go to IDLE.
- DONE: hold until start_deb=0, then go to IDLE. No further triggers in the same window.
- fg_edge outside ARMED is dropped, not queued. An fg_edge in the same cycle ARMED is entered is accepted only from the following cycle.
- Simultaneous fg_edge and start_deb fall in ARMED: the start fall wins and the state goes to IDLE.
- State encoding is internal and not exported.

Optional Feature:
READY_TIMEOUT_EN
- Defined: WAIT_ACK and WAIT_RDY share a counter cleared on FIRE exit. If it reaches TIMEOUT_CYCLES, go to FAULT, which sets fault=1 and blocks triggers. FAULT exits to IDLE only when start_deb=0, which also clears fault.
- Undefined: no counter. WAIT_ACK and WAIT_RDY wait indefinitely, and fault is tied 0.

Test Plan:
- Single shot: start high at 10 ms, fg rising at 12 ms, trig_delay=100 → one 20-clock output_trigger exactly 104 clocks after the fg sample, shot_count=1.
- Detector handshake: drop detector_ready for 6400 us after each trigger, with fg period 10 ms and MAX_SHOTS=4, start high 50 ms → exactly 4 pulses, then done=1. A 5th fg edge produces no pulse, and start fall returns to IDLE.
- Start bounce and abort: start toggles every 3 clocks for 40 clocks → armed stays 0. Then start held high, fg edge with trig_delay=1000, start low 200 clocks later → no pulse, state IDLE.
- fg while busy: an fg edge during WAIT_RDY is ignored → no extra pulse and shot_count unchanged. trig_delay=0 gives pulse latency SYNC_STAGES+2 = 4 clocks.
- Reset mid-FIRE: assert reset 5 clocks into a pulse → output_trigger=0 and shot_count=0 immediately (asynchronously), state IDLE.
- With READY_TIMEOUT_EN and TIMEOUT_CYCLES=1000: detector_ready held 1 after the trigger → fault=1 at 1000 clocks after FIRE exit, later fg edges ignored, start low clears fault.
